// File: rtl/pwm_pkg.sv
// Shared constants for the PWM register path: SPI byte width, synchroniser
// depth default and SPI front-end state encoding.
package pwm_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic SPI_IDLE   = 1'b0;
  localparam logic SPI_ACTIVE = 1'b1;

  typedef enum logic {
    ST_IDLE   = SPI_IDLE,
    ST_ACTIVE = SPI_ACTIVE
  } spi_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchroniser for one asynchronous input; the reset value lets the
// chain come out of reset at the signal's idle level so no false edge appears.
module sync_2ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: synchronises the pins, deserialises MOSI into
// bytes with a byte_sync pulse, and shifts the decoder's response out on MISO.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | cs_n synchronised high; sclk ignored, MISO parked low
//   ST_ACTIVE | cs_n synchronised low; bytes shifted in/out on sclk edges
module spi_slave_if
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DATA_W      = SPI_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              byte_sync,
  output logic [DATA_W-1:0] rx_byte,
  input  logic [DATA_W-1:0] tx_byte
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_hist, cs_hist;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_state_e        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_next;

  sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (sclk), .q (sclk_s)
  );

  sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk (clk), .rst (rst), .d (cs_n), .q (cs_s)
  );

  sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst (rst), .d (mosi), .q (mosi_s)
  );

  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;
  assign cs_fall   = ~cs_s & cs_hist;
  assign cs_rise   = cs_s & ~cs_hist;

  // Between bytes the shifter keeps following tx_byte so a decoder update made
  // after byte_sync still lands before the next byte's first rise.
  always_comb begin
    tx_next = tx_shift;
    if (state == ST_IDLE) begin
      tx_next = tx_byte;
    end else if (sclk_fall && (bit_cnt != '0)) begin
      tx_next = {tx_shift[DATA_W-2:0], 1'b0};
    end else if (!sclk_rise && (bit_cnt == '0)) begin
      tx_next = tx_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b1;
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_byte   <= '0;
      byte_sync <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      sclk_hist <= sclk_s;
      cs_hist   <= cs_s;
      byte_sync <= 1'b0;
      tx_shift  <= tx_next;
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (cs_fall) begin
            state   <= ST_ACTIVE;
            miso    <= tx_next[DATA_W-1];
            miso_oe <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          miso    <= tx_next[DATA_W-1];
          miso_oe <= 1'b1;
          if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_LAST) begin
              rx_byte   <= {rx_shift[DATA_W-2:0], mosi_s};
              byte_sync <= 1'b1;
            end
          end
          // A completing byte above still fires; a partial one is dropped.
          if (cs_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: a bit-banged SPI master drives frames,
// expected bytes are queued and compared whenever byte_sync fires.
`timescale 1ns/1ps
module tb_spi_slave_if;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic       byte_sync;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte = 8'h00;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int sync_cnt = 0;
  logic prev_sync = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] model_rx = 8'h00;
  logic       tx_upd_pend = 1'b0;
  logic [7:0] tx_upd_val = 8'h00;

  spi_slave_if #(.SYNC_STAGES(SYNC_STAGES), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .byte_sync (byte_sync),
    .rx_byte   (rx_byte),
    .tx_byte   (tx_byte)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every byte_sync must match the oldest queued byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_sync) begin
        logic [7:0] exp;
        sync_cnt++;
        tests++;
        if (prev_sync) begin
          fails++;
          $display("FAIL byte_sync_width: high on consecutive cycles, required single cycle");
        end
        tests++;
        if ((cyc - rise_cyc) !== (SYNC_STAGES + 1)) begin
          fails++;
          $display("FAIL byte_sync_latency: got %0d clks, required %0d", cyc - rise_cyc, SYNC_STAGES + 1);
        end
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_byte_sync: rx_byte=%h, none expected", rx_byte);
        end else begin
          exp = exp_q.pop_front();
          if (rx_byte !== exp) begin
            fails++;
            $display("FAIL rx_byte: got %h, required %h", rx_byte, exp);
          end
        end
        if (tx_upd_pend) begin
          tx_byte = tx_upd_val;
          tx_upd_pend = 1'b0;
        end
      end
      prev_sync = byte_sync;
    end else begin
      prev_sync = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic spi_bit(input logic b, input logic end_cs, output logic sampled);
    mosi = b;
    repeat (5) @(posedge clk);
    #1;
    sampled = miso;
    sclk = 1'b1;
    if (end_cs) cs_n = 1'b1;
    rise_cyc = cyc;
    repeat (5) @(posedge clk);
    #1;
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] d, input logic push, input logic end_cs,
                          output logic [7:0] got);
    logic s;
    if (push) begin
      exp_q.push_back(d);
      model_rx = d;
    end
    for (int i = 7; i >= 0; i--) begin
      spi_bit(d[i], end_cs && (i == 0), s);
      got[i] = s;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic cs_high();
    repeat (5) @(posedge clk);
    #1;
    cs_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int s0;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if ({miso, miso_oe, byte_sync, rx_byte} !== 11'h000) begin
      fails++;
      $display("FAIL reset_in_rst: miso=%b oe=%b sync=%b rx=%h, required all 0", miso, miso_oe, byte_sync, rx_byte);
    end
    rst = 1'b0;
    s0 = sync_cnt;
    repeat (100) @(posedge clk);
    #1;
    tests++;
    if (sync_cnt - s0 !== 0) begin
      fails++;
      $display("FAIL reset_no_sync: got %0d pulses, required 0", sync_cnt - s0);
    end
    tests++;
    if ({miso, miso_oe, rx_byte} !== 10'h000) begin
      fails++;
      $display("FAIL reset_release: miso=%b oe=%b rx=%h, required 0 0 00", miso, miso_oe, rx_byte);
    end
  endtask

  task automatic test_single_byte();
    int s0;
    logic [7:0] got;
    tx_byte = 8'h3C;
    s0 = sync_cnt;
    cs_low();
    tests++;
    if (miso_oe !== 1'b1) begin
      fails++;
      $display("FAIL active_oe: got %b, required 1", miso_oe);
    end
    spi_byte(8'hA5, 1'b1, 1'b0, got);
    cs_high();
    tests++;
    if (got !== 8'h3C) begin
      fails++;
      $display("FAIL miso_single: got %h, required 3c", got);
    end
    tests++;
    if (sync_cnt - s0 !== 1) begin
      fails++;
      $display("FAIL single_count: got %0d pulses, required 1", sync_cnt - s0);
    end
    tests++;
    if (miso_oe !== 1'b0 || miso !== 1'b0) begin
      fails++;
      $display("FAIL idle_miso: oe=%b miso=%b, required 0 0", miso_oe, miso);
    end
  endtask

  task automatic test_tx_update();
    logic [7:0] got0, got1;
    tx_byte = 8'h3C;
    tx_upd_val = 8'hC3;
    tx_upd_pend = 1'b1;
    cs_low();
    spi_byte(8'h00, 1'b1, 1'b0, got0);
    spi_byte(8'hFF, 1'b1, 1'b0, got1);
    cs_high();
    tests++;
    if (got0 !== 8'h3C) begin
      fails++;
      $display("FAIL miso_first: got %h, required 3c", got0);
    end
    tests++;
    if (got1 !== 8'hC3) begin
      fails++;
      $display("FAIL miso_updated: got %h, required c3", got1);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    logic [7:0] got;
    s0 = sync_cnt;
    cs_low();
    spi_byte(8'h81, 1'b1, 1'b0, got);
    spi_byte(8'h7E, 1'b1, 1'b0, got);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (dut.bit_cnt !== 3'd0) begin
      fails++;
      $display("FAIL b2b_bit_cnt: got %0d, required 0", dut.bit_cnt);
    end
    cs_high();
    tests++;
    if (sync_cnt - s0 !== 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d pulses, required 2", sync_cnt - s0);
    end
    tests++;
    if (rx_byte !== 8'h7E) begin
      fails++;
      $display("FAIL b2b_rx_hold: got %h, required 7e", rx_byte);
    end
  endtask

  task automatic test_abort();
    int s0;
    logic s;
    logic [7:0] got;
    s0 = sync_cnt;
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, s);
    cs_high();
    tests++;
    if (sync_cnt - s0 !== 0) begin
      fails++;
      $display("FAIL abort_count: got %0d pulses, required 0", sync_cnt - s0);
    end
    tests++;
    if (rx_byte !== model_rx) begin
      fails++;
      $display("FAIL abort_rx_hold: got %h, required %h", rx_byte, model_rx);
    end
    tests++;
    if (dut.bit_cnt !== 3'd0) begin
      fails++;
      $display("FAIL abort_bit_cnt: got %0d, required 0", dut.bit_cnt);
    end
    cs_low();
    spi_byte(8'h12, 1'b1, 1'b0, got);
    cs_high();
    tests++;
    if (rx_byte !== 8'h12 || sync_cnt - s0 !== 1) begin
      fails++;
      $display("FAIL abort_next: rx=%h pulses=%0d, required 12 and 1", rx_byte, sync_cnt - s0);
    end
  endtask

  task automatic test_cs_same_edge();
    int s0;
    logic [7:0] got;
    s0 = sync_cnt;
    cs_low();
    spi_byte(8'hC7, 1'b1, 1'b1, got);
    cs_high();
    tests++;
    if (sync_cnt - s0 !== 1 || rx_byte !== 8'hC7) begin
      fails++;
      $display("FAIL cs_same_edge: pulses=%0d rx=%h, required 1 and c7", sync_cnt - s0, rx_byte);
    end
  endtask

  task automatic test_rst_mid_frame();
    int s0;
    logic s;
    logic [7:0] got;
    cs_low();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, s);
    rst = 1'b1;
    #1;
    model_rx = 8'h00;
    tests++;
    if ({miso, miso_oe, byte_sync, rx_byte} !== 11'h000 || dut.bit_cnt !== 3'd0) begin
      fails++;
      $display("FAIL rst_mid: miso=%b oe=%b sync=%b rx=%h cnt=%0d, required all 0",
               miso, miso_oe, byte_sync, rx_byte, dut.bit_cnt);
    end
    repeat (3) @(posedge clk);
    #1;
    cs_n = 1'b1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    s0 = sync_cnt;
    cs_low();
    spi_byte(8'h5A, 1'b1, 1'b0, got);
    cs_high();
    tests++;
    if (sync_cnt - s0 !== 1 || rx_byte !== 8'h5A) begin
      fails++;
      $display("FAIL rst_restart: pulses=%0d rx=%h, required 1 and 5a", sync_cnt - s0, rx_byte);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_tx_update();
    test_back_to_back();
    test_abort();
    test_cs_same_edge();
    test_rst_mid_frame();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_bytes: %0d expected bytes never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
